riscv_lsu: RTL and testbench

//  Load/store unit directly downstream of the single-cycle core's memory port.
//  - Takes the core's memop/mem_wen/mem_addr/memdata request.
//  - Runs a valid/ready request plus response-valid transaction on the data bus.
//  - Stalls the core until the access completes.
//  - Returns the aligned, sign/zero-extended load value on rdata.
//  - Flags misaligned accesses and bus timeouts instead of issuing them.

---
 rtl/riscv_lsu_pkg.sv | 33 +++
 rtl/riscv_lsu_align.sv | 68 ++++++
 rtl/riscv_lsu.sv | 184 ++++++++++++++++++
 tb/tb_riscv_lsu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// +--------------------------------------------------------------------+
// | riscv_lsu_pkg : shared codes for the load/store unit               |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/riscv_lsu_align.sv
// +--------------------------------------------------------------------+
// | riscv_lsu_align : store lane steering, load extraction, legality   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  st_memop_i,
    input  logic [1:0]  st_off_i,
    input  logic        st_wen_i,
    input  logic [31:0] st_wdata_i,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    output logic        bad_o,
    input  logic [2:0]  ld_memop_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] w_shift;

    always_comb begin
        case (st_memop_i)
            MEMOP_B:  bad_o = 1'b0;
            MEMOP_H:  bad_o = st_off_i[0];
            MEMOP_W:  bad_o = |st_off_i;
            MEMOP_BU: bad_o = st_wen_i;
            MEMOP_HU: bad_o = st_wen_i | st_off_i[0];
            default:  bad_o = 1'b1;
        endcase
    end

    always_comb begin
        case (st_memop_i)
            MEMOP_B: begin
                bus_wdata_o = {4{st_wdata_i[7:0]}};
                bus_wstrb_o = STRB_BYTE << st_off_i;
            end
            MEMOP_H: begin
                bus_wdata_o = {2{st_wdata_i[15:0]}};
                bus_wstrb_o = STRB_HALF << {st_off_i[1], 1'b0};
            end
            default: begin
                bus_wdata_o = st_wdata_i;
                bus_wstrb_o = STRB_WORD;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0 before extending.
    assign w_shift = rsp_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        case (ld_memop_i)
            MEMOP_B:  ld_data_o = {{24{w_shift[7]}}, w_shift[7:0]};
            MEMOP_BU: ld_data_o = {24'd0, w_shift[7:0]};
            MEMOP_H:  ld_data_o = {{16{w_shift[15]}}, w_shift[15:0]};
            MEMOP_HU: ld_data_o = {16'd0, w_shift[15:0]};
            default:  ld_data_o = rsp_rdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/riscv_lsu.sv
// +--------------------------------------------------------------------+
// | riscv_lsu : stalls the core and runs one bus transaction per access|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_wen_i,
    input  logic [2:0]  req_memop_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  err_o,
    output logic        bus_req_valid_o,
    input  logic        bus_req_ready_i,
    output logic        bus_wen_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_rsp_valid_i,
    input  logic [31:0] bus_rsp_rdata_i
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_valid_q, req_valid_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic [2:0]  memop_q, memop_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic        done_q, done_d;

    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_strb;
    logic        w_bad;
    logic [31:0] w_ld_data;

    riscv_lsu_align u_align (
        .st_memop_i  (req_memop_i),
        .st_off_i    (req_addr_i[1:0]),
        .st_wen_i    (req_wen_i),
        .st_wdata_i  (req_wdata_i),
        .bus_wdata_o (w_st_wdata),
        .bus_wstrb_o (w_st_strb),
        .bad_o       (w_bad),
        .ld_memop_i  (memop_q),
        .ld_off_i    (off_q),
        .rsp_rdata_i (bus_rsp_rdata_i),
        .ld_data_o   (w_ld_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_valid_d = req_valid_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        memop_d     = memop_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (w_bad) begin
                        state_d = ST_DONE;
                        err_d   = ERR_MISALIGN;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = 8'd0;
                        req_valid_d = 1'b1;
                        wen_d       = req_wen_i;
                        addr_d      = {req_addr_i[31:2], 2'b00};
                        wdata_d     = w_st_wdata;
                        strb_d      = req_wen_i ? w_st_strb : STRB_NONE;
                        memop_d     = req_memop_i;
                        off_d       = req_addr_i[1:0];
                    end
                end
            end
            ST_REQ: begin
                if (bus_req_ready_i) begin
                    state_d     = ST_WAIT;
                    req_valid_d = 1'b0;
                    cnt_d       = cnt_q + 8'd1;
                end else if (cnt_q == TO_LAST) begin
                    state_d     = ST_DONE;
                    req_valid_d = 1'b0;
                    err_d       = ERR_TIMEOUT;
                    done_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (bus_rsp_valid_i) begin
                    state_d = ST_DONE;
                    err_d   = ERR_OK;
                    done_d  = 1'b1;
                    if (!wen_q) begin
                        rdata_d = w_ld_data;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_DONE;
                    err_d   = ERR_TIMEOUT;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            req_valid_q <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            strb_q      <= STRB_NONE;
            memop_q     <= 3'd0;
            off_q       <= 2'd0;
            rdata_q     <= 32'd0;
            err_q       <= ERR_OK;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            memop_q     <= memop_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    // Stall is gated by reset so the core is released while the LSU is held.
    assign stall_o = rst_ni & (((state_q == ST_IDLE) & req_valid_i) |
                               (state_q == ST_REQ) | (state_q == ST_WAIT));

    assign done_o          = done_q;
    assign rdata_o         = rdata_q;
    assign err_o           = err_q;
    assign bus_req_valid_o = req_valid_q;
    assign bus_wen_o       = wen_q;
    assign bus_addr_o      = addr_q;
    assign bus_wdata_o     = wdata_q;
    assign bus_wstrb_o     = strb_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_lsu.sv
// +--------------------------------------------------------------------+
// | tb_riscv_lsu : directed vector table plus timeout/reset sequences  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_riscv_lsu;

    typedef struct {
        logic        wen;
        logic [2:0]  memop;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic [31:0] bwdata;
        logic [3:0]  strb;
        int          lat;
    } vec_t;

    localparam int NVEC = 13;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid, req_wen;
    logic [2:0]  req_memop;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        bus_req_valid, bus_req_ready, bus_wen;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_rdata;
    vec_t        vecs [NVEC];

    always #5 clk = ~clk;

    riscv_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid),
        .req_wen_i       (req_wen),
        .req_memop_i     (req_memop),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .stall_o         (stall),
        .done_o          (done),
        .rdata_o         (rdata),
        .err_o           (err),
        .bus_req_valid_o (bus_req_valid),
        .bus_req_ready_i (bus_req_ready),
        .bus_wen_o       (bus_wen),
        .bus_addr_o      (bus_addr),
        .bus_wdata_o     (bus_wdata),
        .bus_wstrb_o     (bus_wstrb),
        .bus_rsp_valid_i (bus_rsp_valid),
        .bus_rsp_rdata_i (bus_rsp_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one request and follow it until done (or the cycle budget runs out).
    task automatic access(input logic wen, input logic [2:0] memop,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rsp,
                          output int lat, output int reqs, output logic stall0,
                          output logic [31:0] a_s, output logic [31:0] wd_s,
                          output logic [3:0] st_s, output logic wen_s);
        @(negedge clk);
        req_valid     = 1'b1;
        req_wen       = wen;
        req_memop     = memop;
        req_addr      = addr;
        req_wdata     = wdata;
        bus_rsp_rdata = rsp;
        #1 stall0 = stall;
        lat = 0; reqs = 0; a_s = '0; wd_s = '0; st_s = '0; wen_s = 1'b0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            if (bus_req_valid) begin
                reqs++;
                a_s = bus_addr; wd_s = bus_wdata; st_s = bus_wstrb; wen_s = bus_wen;
            end
            if (done) break;
        end
    endtask

    initial begin
        int lat, reqs;
        logic stall0, wen_s;
        logic [31:0] a_s, wd_s;
        logic [3:0] st_s;
        bit saw_done;

        //           wen   memop   addr          wdata         rsp           err    rdata         bwdata        strb    lat
        vecs[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 2'b00, 32'hFFFF_FF80, 32'h0,        4'b0000, 3};
        vecs[1]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 2'b00, 32'h0000_BEEF, 32'h0,        4'b0000, 3};
        vecs[2]  = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 2'b00, 32'hFFFF_BEEF, 32'h0,        4'b0000, 3};
        vecs[3]  = '{1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'h5555_5555, 2'b00, 32'h0,        32'hABAB_ABAB, 4'b0010, 3};
        vecs[4]  = '{1'b1, 3'b001, 32'h0000_3002, 32'h0000_CAFE, 32'h5555_5555, 2'b00, 32'h0,        32'hCAFE_CAFE, 4'b1100, 3};
        vecs[5]  = '{1'b0, 3'b010, 32'h0000_4002, 32'h0,        32'h1111_1111, 2'b01, 32'h0,        32'h0,        4'b0000, 1};
        vecs[6]  = '{1'b0, 3'b011, 32'h0000_5000, 32'h0,        32'h1111_1111, 2'b01, 32'h0,        32'h0,        4'b0000, 1};
        vecs[7]  = '{1'b0, 3'b010, 32'h0000_6000, 32'h0,        32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 32'h0,        4'b0000, 3};
        vecs[8]  = '{1'b0, 3'b100, 32'h0000_7001, 32'h0,        32'h0000_8000, 2'b00, 32'h0000_0080, 32'h0,        4'b0000, 3};
        vecs[9]  = '{1'b1, 3'b010, 32'h0000_8004, 32'h1122_3344, 32'h0,        2'b00, 32'h0,        32'h1122_3344, 4'b1111, 3};
        vecs[10] = '{1'b1, 3'b100, 32'h0000_9000, 32'h0000_00AA, 32'h0,        2'b01, 32'h0,        32'h0,        4'b0000, 1};
        vecs[11] = '{1'b0, 3'b001, 32'h0000_9001, 32'h0,        32'h0,        2'b01, 32'h0,        32'h0,        4'b0000, 1};
        vecs[12] = '{1'b0, 3'b000, 32'h0000_A000, 32'h0,        32'h0000_007F, 2'b00, 32'h0000_007F, 32'h0,        4'b0000, 3};

        rst_ni = 1'b0; req_valid = 1'b1; req_wen = 1'b0; req_memop = 3'b010;
        req_addr = 32'h0; req_wdata = 32'h0;
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0;
        model_rdata = 32'h0;

        #2;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bus_req_valid", {31'd0, bus_req_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        chk("rst_bus_fields", {bus_addr ^ bus_wdata}, 32'd0);
        chk("rst_strb_wen", {27'd0, bus_wstrb, bus_wen}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            access(vecs[i].wen, vecs[i].memop, vecs[i].addr, vecs[i].wdata, vecs[i].rsp,
                   lat, reqs, stall0, a_s, wd_s, st_s, wen_s);
            if (vecs[i].err == 2'b00 && !vecs[i].wen) model_rdata = vecs[i].rdata;
            chk($sformatf("v%0d_stall_idle", i), {31'd0, stall0}, 32'd1);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_err", i), {30'd0, err}, {30'd0, vecs[i].err});
            chk($sformatf("v%0d_rdata", i), rdata, model_rdata);
            chk($sformatf("v%0d_stall_done", i), {31'd0, stall}, 32'd0);
            if (vecs[i].err == 2'b00) begin
                chk($sformatf("v%0d_nreq", i), reqs, 1);
                chk($sformatf("v%0d_bus_addr", i), a_s, {vecs[i].addr[31:2], 2'b00});
                chk($sformatf("v%0d_bus_wen", i), {31'd0, wen_s}, {31'd0, vecs[i].wen});
                chk($sformatf("v%0d_bus_wstrb", i), {28'd0, st_s}, {28'd0, vecs[i].strb});
                if (vecs[i].wen) chk($sformatf("v%0d_bus_wdata", i), wd_s, vecs[i].bwdata);
            end else begin
                chk($sformatf("v%0d_nreq", i), reqs, 0);
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // Timeout: bus never accepts; expect 8 REQ cycles then err 10.
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h7777_7777,
               lat, reqs, stall0, a_s, wd_s, st_s, wen_s);
        chk("to_req_cycles", reqs, 8);
        chk("to_latency", lat, 9);
        chk("to_err", {30'd0, err}, 32'd2);
        chk("to_rdata", rdata, model_rdata);
        chk("to_bus_req_valid", {31'd0, bus_req_valid}, 32'd0);
        bus_rsp_valid = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || bus_req_valid) saw_done = 1'b1;
        end
        chk("late_rsp_no_activity", {31'd0, saw_done}, 32'd0);
        chk("late_rsp_rdata", rdata, model_rdata);

        // Reset while waiting for the response.
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_memop = 3'b010; req_addr = 32'h0000_0200;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rw_in_req", {31'd0, bus_req_valid}, 32'd1);
        @(negedge clk);
        chk("rw_stall_in_wait", {31'd0, stall}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rw_stall_rst", {31'd0, stall}, 32'd0);
        chk("rw_bus_req_valid_rst", {31'd0, bus_req_valid}, 32'd0);
        bus_rsp_valid = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_ni = 1'b1;
        model_rdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done || stall) saw_done = 1'b1;
        end
        chk("rw_no_done", {31'd0, saw_done}, 32'd0);
        chk("rw_rdata_cleared", rdata, 32'd0);
        access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0BAD_F00D,
               lat, reqs, stall0, a_s, wd_s, st_s, wen_s);
        chk("rw_next_latency", lat, 3);
        chk("rw_next_rdata", rdata, 32'h0BAD_F00D);
        chk("rw_next_err", {30'd0, err}, 32'd0);
        chk("rw_next_addr", a_s, 32'h0000_0300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
